math_stack_seq: RTL and testbench

Command sequencer for the byte-wide math datapath. It accepts opcode/operand commands over a valid/ready handshake, keeps the operands on a small LIFO stack, and executes single-cycle ALU ops and an iterative shift-add multiply. It sits between the chip pin interface and the arithmetic core: the input byte and op pins feed it commands, and the output pins show the top of the stack.

---
 rtl/math_stack_seq_if.sv | 23 ++
 rtl/math_stack_seq.sv | 122 ++++++++++++
 tb/tb_math_stack_seq.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/math_stack_seq_if.sv
// math_stack_seq_if: command handshake and stack status bundle for math_stack_seq
interface math_stack_seq_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [3:0]                 cmd_op;
    logic [WIDTH-1:0]           cmd_data;
    logic [WIDTH-1:0]           top;
    logic [$clog2(DEPTH):0]     depth;
    logic                       busy;
    logic                       carry;
    logic                       err;
    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, top, depth, busy, carry, err
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, top, depth, busy, carry, err
    );
endinterface

// File: rtl/math_stack_seq.sv
// math_stack_seq: LIFO operand stack with single-cycle ALU ops and a shift-add multiplier
module math_stack_seq #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic rst,
    math_stack_seq_if.slave bus
);
    localparam int DW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(WIDTH);
    localparam logic [3:0] OP_PUSH = 4'h1, OP_DROP = 4'h2, OP_DUP = 4'h3, OP_SWAP = 4'h4;
    localparam logic [3:0] OP_ADD = 4'h5, OP_SUB = 4'h6, OP_MUL = 4'h7, OP_AND = 4'h8;
    localparam logic [3:0] OP_OR = 4'h9, OP_XOR = 4'hA, OP_CLR = 4'hC;
    typedef enum logic {S_IDLE, S_MUL} state_t;
    state_t state, nxt;
    logic [WIDTH-1:0]   stk [DEPTH];
    logic [DW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand, prod, prod_nxt;
    logic [WIDTH-1:0]   mplier, t, n, res;
    logic [WIDTH:0]     sum;
    logic [SW-1:0]      step;
    logic [1:0]         need;
    logic [3:0]         op;
    logic               acc, under, over, cy, last, binop, carry_r, err_r;
    assign op   = bus.cmd_op;
    assign t    = stk[0];
    assign n    = stk[1];
    assign acc  = bus.cmd_valid && state == S_IDLE;
    assign last = state == S_MUL && step == SW'(WIDTH - 1);
    assign bus.cmd_ready = state == S_IDLE;
    assign bus.busy      = state == S_MUL;
    assign bus.top       = stk[0];
    assign bus.depth     = cnt;
    assign bus.carry     = carry_r;
    assign bus.err       = err_r;
    // Operand checks, ALU result and the next multiply partial product
    always_comb begin
        need     = (op == OP_DROP || op == OP_DUP) ? 2'd1 :
                   (op == OP_SWAP || (op >= OP_ADD && op <= OP_XOR)) ? 2'd2 : 2'd0;
        under    = cnt < DW'(need);
        over     = (op == OP_PUSH || op == OP_DUP) && cnt == DW'(DEPTH);
        binop    = op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_OR || op == OP_XOR;
        sum      = {1'b0, n} + {1'b0, t};
        res      = op == OP_ADD ? sum[WIDTH-1:0] :
                   op == OP_SUB ? n - t :
                   op == OP_AND ? n & t :
                   op == OP_OR  ? n | t : n ^ t;
        cy       = op == OP_ADD ? sum[WIDTH] : op == OP_SUB ? t > n : 1'b0;
        prod_nxt = prod + (mplier[0] ? mcand : '0);
    end
    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end
    // Enter MUL on an accepted, well-formed multiply; leave after the last step
    always_comb begin
        nxt = state == S_IDLE ? ((acc && op == OP_MUL && !under) ? S_MUL : S_IDLE)
                              : (last ? S_IDLE : S_MUL);
    end
    // Shift-add multiplier: latch operands at start, one multiplier bit per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            step   <= '0;
        end else if (acc && op == OP_MUL && !under) begin
            mcand  <= (2*WIDTH)'(n);
            mplier <= t;
            prod   <= '0;
            step   <= '0;
        end else if (state == S_MUL) begin
            prod   <= prod_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            step   <= step + 1'b1;
        end
    end
    // Stack storage (entry 0 is the top; popped slots refill with zero) and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
            cnt     <= '0;
            carry_r <= 1'b0;
            err_r   <= 1'b0;
        end else if (last) begin
            stk[0] <= prod_nxt[WIDTH-1:0];
            for (int i = 1; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
            stk[DEPTH-1] <= '0;
            cnt     <= cnt - 1'b1;
            carry_r <= |prod_nxt[2*WIDTH-1:WIDTH];
        end else if (acc) begin
            if (op == OP_CLR) begin
                for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
                cnt     <= '0;
                carry_r <= 1'b0;
                err_r   <= 1'b0;
            end else if (under || over) begin
                err_r <= 1'b1;
            end else if (op == OP_PUSH || op == OP_DUP) begin
                for (int i = 1; i < DEPTH; i++) stk[i] <= stk[i-1];
                stk[0] <= op == OP_PUSH ? bus.cmd_data : t;
                cnt    <= cnt + 1'b1;
            end else if (op == OP_DROP) begin
                for (int i = 0; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
                stk[DEPTH-1] <= '0;
                cnt <= cnt - 1'b1;
            end else if (op == OP_SWAP) begin
                stk[0] <= n;
                stk[1] <= t;
            end else if (binop) begin
                stk[0] <= res;
                for (int i = 1; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
                stk[DEPTH-1] <= '0;
                cnt     <= cnt - 1'b1;
                carry_r <= cy;
            end
        end
    end
endmodule

// File: tb/tb_math_stack_seq.sv
// tb_math_stack_seq: directed and random commands checked against a queue-based stack model
module tb_math_stack_seq;
    localparam int W = 8;
    localparam int D = 4;
    localparam int MASK = (1 << W) - 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    math_stack_seq_if #(.WIDTH(W), .DEPTH(D)) ifc();
    math_stack_seq #(.DEPTH(D), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(ifc));
    always #5 clk = ~clk;
    int total = 0;
    int bad = 0;
    int q[$];
    int m_carry = 0;
    int m_err = 0;
    bit mul_pend = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // Applies one accepted command to the reference stack; returns 1 when a multiply starts
    function automatic bit model(input int op, input int d);
        int need, t, n, r;
        need = (op == 2 || op == 3) ? 1 : ((op >= 4 && op <= 10) ? 2 : 0);
        if (op == 12) begin
            q.delete();
            m_err = 0;
            m_carry = 0;
            return 0;
        end
        if (q.size() < need || ((op == 1 || op == 3) && q.size() == D)) begin
            m_err = 1;
            return 0;
        end
        case (op)
            1: q.push_back(d & MASK);
            2: void'(q.pop_back());
            3: q.push_back(q[$]);
            4: begin
                t = q.pop_back();
                n = q.pop_back();
                q.push_back(t);
                q.push_back(n);
            end
            5, 6, 7, 8, 9, 10: begin
                t = q.pop_back();
                n = q.pop_back();
                case (op)
                    5: r = n + t;
                    6: r = n - t;
                    7: r = n * t;
                    8: r = n & t;
                    9: r = n | t;
                    default: r = n ^ t;
                endcase
                m_carry = (op == 6) ? int'(t > n) : ((op == 5 || op == 7) ? int'((r >> W) != 0) : 0);
                q.push_back(r & MASK);
            end
            default: ;
        endcase
        return op == 7;
    endfunction
    task automatic check_all(input string tag);
        chk({tag, ".top"}, ifc.top, q.size() > 0 ? q[$] : 0);
        chk({tag, ".depth"}, ifc.depth, q.size());
        chk({tag, ".carry"}, ifc.carry, m_carry);
        chk({tag, ".err"}, ifc.err, m_err);
        chk({tag, ".busy"}, ifc.busy, 0);
        chk({tag, ".ready"}, ifc.cmd_ready, 1);
    endtask
    task automatic rst_chk(input string tag);
        chk({tag, ".top"}, ifc.top, 0);
        chk({tag, ".depth"}, ifc.depth, 0);
        chk({tag, ".busy"}, ifc.busy, 0);
        chk({tag, ".carry"}, ifc.carry, 0);
        chk({tag, ".err"}, ifc.err, 0);
        chk({tag, ".ready"}, ifc.cmd_ready, 1);
    endtask
    // Called at a falling edge; holds the command until accepted, returns at the next falling edge
    task automatic cmd(input int op, input int d);
        int waits = 0;
        int old;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op = op[3:0];
        ifc.cmd_data = d[W-1:0];
        while (!ifc.cmd_ready && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        if (mul_pend) begin
            chk("mul_busy_cycles", waits, W);
            check_all("mul_done");
            mul_pend = 0;
        end else begin
            chk("ready_wait", waits, 0);
        end
        old = q.size();
        @(posedge clk);
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        if (model(op, d)) begin
            mul_pend = 1;
            chk("mul_busy", ifc.busy, 1);
            chk("mul_ready", ifc.cmd_ready, 0);
            chk("mul_depth_hold", ifc.depth, old);
        end else begin
            check_all($sformatf("op%0h", op));
        end
    endtask
    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op = 4'h0;
        ifc.cmd_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rst_chk("reset");
        cmd(1, 'h05); cmd(1, 'h03); cmd(6, 0);
        chk("sub1_top", ifc.top, 'h02); chk("sub1_depth", ifc.depth, 1); chk("sub1_c", ifc.carry, 0);
        cmd(12, 0); cmd(1, 'h03); cmd(1, 'h05); cmd(6, 0);
        chk("sub2_top", ifc.top, 'hFE); chk("sub2_c", ifc.carry, 1);
        cmd(12, 0); cmd(1, 'hC8); cmd(1, 'h64); cmd(5, 0);
        chk("add_top", ifc.top, 'h2C); chk("add_c", ifc.carry, 1);
        cmd(3, 0); cmd(10, 0);
        chk("xor_top", ifc.top, 0); chk("xor_c", ifc.carry, 0); chk("xor_depth", ifc.depth, 1);
        cmd(12, 0); cmd(1, 'h0C); cmd(1, 'h0B); cmd(7, 0); cmd(1, 'h55);
        chk("held_push_top", ifc.top, 'h55); chk("held_push_depth", ifc.depth, 2);
        cmd(2, 0);
        chk("mul1_top", ifc.top, 'h84); chk("mul1_c", ifc.carry, 0);
        cmd(12, 0); cmd(1, 'h20); cmd(1, 'h10); cmd(7, 0); cmd(0, 0);
        chk("mul2_top", ifc.top, 'h00); chk("mul2_c", ifc.carry, 1);
        cmd(12, 0);
        for (int i = 1; i <= 5; i++) cmd(1, i);
        chk("ovf_depth", ifc.depth, 4); chk("ovf_top", ifc.top, 4); chk("ovf_err", ifc.err, 1);
        cmd(12, 0);
        chk("clr_depth", ifc.depth, 0); chk("clr_err", ifc.err, 0);
        cmd(5, 0);
        chk("unf_err", ifc.err, 1); chk("unf_depth", ifc.depth, 0); chk("unf_busy", ifc.busy, 0);
        cmd(12, 0); cmd(1, 'h03); cmd(1, 'h09); cmd(7, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 rst_chk("mid_mul_rst");
        q.delete();
        m_carry = 0;
        m_err = 0;
        mul_pend = 0;
        @(negedge clk);
        rst = 1'b0;
        cmd(1, 'h07);
        chk("post_rst_top", ifc.top, 'h07); chk("post_rst_depth", ifc.depth, 1);
        repeat (400) cmd($urandom_range(0, 15), $urandom_range(0, MASK));
        cmd(0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
